// File: rtl/scan_reg_chain_if.sv
// Bundle of the scan register's functional, scan and engine signals.
// master drives the controls and observes the register; slave is the register itself.
interface scan_reg_chain_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] d;
    logic             test;
    logic             sin;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, d, test, sin, start,
        input  q, sout, busy, done
    );

    modport slave (
        input  en, d, test, sin, start,
        output q, sout, busy, done
    );
endinterface

// File: rtl/scan_reg_chain.sv
// WIDTH-bit scan register: parallel capture, manual scan shift and a WIDTH-cycle auto shift engine.
// Define SCAN_LOOPBACK_EN to rotate sout back into q[0] during auto shifts.
module scan_reg_chain #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             clk,
    input logic             reset,
    scan_reg_chain_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             shift_bit;
    logic [WIDTH-1:0] q_shifted;

`ifdef SCAN_LOOPBACK_EN
    // Auto shifts rotate so q is restored at done; manual shifts still take sin.
    assign shift_bit = (state == SHIFT) ? q[WIDTH-1] : bus.sin;
`else
    assign shift_bit = bus.sin;
`endif

    assign q_shifted = {q[WIDTH-2:0], shift_bit};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        q_next     = q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SHIFT;
                    cnt_next   = CW'(WIDTH - 1);
                end
                if (bus.test) begin
                    q_next = q_shifted;
                end else if (bus.en) begin
                    q_next = bus.d;
                end
            end
            SHIFT: begin
                q_next = q_shifted;
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= RESET_VAL;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            q     <= q_next;
        end
    end

    assign bus.q    = q;
    assign bus.sout = q[WIDTH-1];
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);

    a_busy_done_excl: assert property (@(posedge clk) !(bus.busy && bus.done));
    a_done_one_cycle: assert property (@(posedge clk) disable iff (reset) bus.done |=> !bus.done);
    a_done_after_shift: assert property (@(posedge clk) disable iff (reset) $rose(bus.done) |-> $past(bus.busy));

endmodule

// File: doc/scan_reg_chain.md
Name: scan_reg_chain

Overview:
- Parametrised scan register: the next generation of the 4-bit scan flop chain.
- Provides WIDTH-bit parallel capture with enable, manual scan shift, and an autonomous shift-out engine.
- The engine unloads or loads the whole chain in exactly WIDTH cycles on a single start pulse.
- Sits between functional datapath registers and the test/debug port; chains of these are concatenated through sin/sout.

Parameters:
- WIDTH, 8, number of scan cells (>=2).
- RESET_VAL, '0, value loaded into q on reset (WIDTH bits).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- en, input, 1, functional capture enable.
- d, input, WIDTH, functional parallel data.
- test, input, 1, manual scan mode: shift one bit per cycle while high.
- sin, input, 1, scan serial in; enters q[0].
- start, input, 1, request an automatic WIDTH-bit shift; sampled only in IDLE.
- q, output, WIDTH, register contents.
- sout, output, 1, scan serial out = q[WIDTH-1] (combinational from q).
- busy, output, 1, high while the engine is in SHIFT.
- done, output, 1, one-cycle pulse after the last automatic shift.

Behaviour:
- Single clock domain. All state updates on posedge clk.
- Reset is synchronous and active-high, and has top priority:
  - q = RESET_VAL.
  - FSM = IDLE, counter = 0.
  - busy = 0, done = 0.
  - Reset applied mid-SHIFT aborts the shift with no done pulse.
- Shift operation (common to manual and auto modes):
  - q[0] <= sin, and q[i] <= q[i-1] for i = 1..WIDTH-1.
  - sout presents the bit leaving the chain before each edge.
- Update priority per cycle: reset > FSM in SHIFT (auto shift) > test (manual shift) > en (q <= d) > hold.
- FSM states:
  - IDLE: start=1 -> SHIFT and counter = WIDTH-1. No shift occurs on this edge; test/en act normally on this edge.
  - SHIFT: one shift per cycle; counter decrements. counter==0 at the edge -> DONE after performing the final shift. Exactly WIDTH shifts happen in total. en, test and start are ignored.
  - DONE: done=1 for this one cycle; q holds regardless of en/test; start ignored; -> IDLE.
- busy = (state == SHIFT); done = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
- The counter is $clog2(WIDTH) bits; it never wraps during normal operation.
- start held high continuously relaunches from IDLE, giving a shift/done/idle cadence of WIDTH+2 cycles.
- sout is valid in all states, including reset (RESET_VAL[WIDTH-1]).

Optional Feature:
- Macro: SCAN_LOOPBACK_EN.
- Defined:
  - During auto SHIFT, q[0] takes sout instead of sin (rotate), so q returns to its pre-start value at done while the full word streams out on sout.
  - Manual test shifts still use sin.
- Undefined: auto SHIFT uses sin; no rotate path is present.

Test Plan:
1. reset=1 for 2 cycles, WIDTH=8, RESET_VAL=0x00 -> q=0x00, sout=0, busy=0, done=0.
2. en=1, d=0xA5 for one cycle, then en=0, d=0xFF -> q=0xA5 after the first edge and holds 0xA5 afterwards.
3. q=0xA5, test=1, sin=1,0,1,1 over four cycles:
   - sout before each edge = 1,0,1,0.
   - q after each edge = 0x4B, 0x96, 0x2D, 0x5B.
4. q=0x3C, start pulse, sin=0:
   - busy=1 for exactly 8 cycles; sout during SHIFT = 0,0,1,1,1,1,0,0.
   - done=1 on the following single cycle; final q=0x00.
   - en=1, d=0xFF during SHIFT has no effect.
5. Start pulses while busy=1 and during DONE are ignored (exactly 8 shifts, one done).
   - reset asserted on the 4th SHIFT cycle -> q=0x00, IDLE, no done.
   - A later start completes normally.
6. With SCAN_LOOPBACK_EN: q=0x3C, start -> sout stream 0,0,1,1,1,1,0,0 and q=0x3C at done. Without it and sin=1 -> q=0xFF at done.
